// File: rtl/note_pkg.sv
// Shared note constants, frequency table, elaboration-time half-period math
// and the player state type.
package note_pkg;

   localparam int w_note = 12;

   localparam logic [w_note-1:0] C  = 12'b1000_0000_0000;
   localparam logic [w_note-1:0] Cs = 12'b0100_0000_0000;
   localparam logic [w_note-1:0] D  = 12'b0010_0000_0000;
   localparam logic [w_note-1:0] Ds = 12'b0001_0000_0000;
   localparam logic [w_note-1:0] E  = 12'b0000_1000_0000;
   localparam logic [w_note-1:0] F  = 12'b0000_0100_0000;
   localparam logic [w_note-1:0] Fs = 12'b0000_0010_0000;
   localparam logic [w_note-1:0] G  = 12'b0000_0001_0000;
   localparam logic [w_note-1:0] Gs = 12'b0000_0000_1000;
   localparam logic [w_note-1:0] A  = 12'b0000_0000_0100;
   localparam logic [w_note-1:0] As = 12'b0000_0000_0010;
   localparam logic [w_note-1:0] B  = 12'b0000_0000_0001;

   localparam logic [w_note-1:0] Df = Cs;
   localparam logic [w_note-1:0] Ef = Ds;
   localparam logic [w_note-1:0] Gf = Fs;
   localparam logic [w_note-1:0] Af = Gs;
   localparam logic [w_note-1:0] Bf = As;

   localparam int unsigned freq_100_c  = 26163;
   localparam int unsigned freq_100_cs = 27718;
   localparam int unsigned freq_100_d  = 29366;
   localparam int unsigned freq_100_ds = 31113;
   localparam int unsigned freq_100_e  = 32963;
   localparam int unsigned freq_100_f  = 34923;
   localparam int unsigned freq_100_fs = 36999;
   localparam int unsigned freq_100_g  = 39200;
   localparam int unsigned freq_100_gs = 41530;
   localparam int unsigned freq_100_a  = 44000;
   localparam int unsigned freq_100_as = 46616;
   localparam int unsigned freq_100_b  = 49388;

   // Indexed by note bit position: entry 0 is B, entry 11 is C.
   localparam int unsigned freq_100_tab [w_note] = '{
      freq_100_b, freq_100_as, freq_100_a, freq_100_gs, freq_100_g, freq_100_fs,
      freq_100_f, freq_100_e, freq_100_ds, freq_100_d, freq_100_cs, freq_100_c};

   function automatic logic [63:0] half_period(input int unsigned clk_mhz,
                                               input int unsigned freq_100,
                                               input int unsigned octave);
      return (64'(clk_mhz) * 64'd100_000_000 / (64'd2 * 64'(freq_100))) >> octave;
   endfunction

   typedef enum logic [1:0] {IDLE, PLAY, GAP} tone_state_t;

endpackage

// File: rtl/ms_timer.sv
// Millisecond down-counter: a 1 ms prescaler steps the ms count; expired
// flags the final cycle of the last millisecond.
module ms_timer #(
   parameter int clk_mhz = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] ms,
   output logic        expired
);

   localparam logic [16:0] pre_max = 17'(clk_mhz * 1000 - 1);

   logic [16:0] pre;
   logic [15:0] ms_cnt;

   assign expired = (ms_cnt == 16'd1) && (pre == pre_max);

   // A zero count parks the timer, so it sits quietly while the player idles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre    <= '0;
         ms_cnt <= '0;
      end else if (load) begin
         pre    <= '0;
         ms_cnt <= ms;
      end else if (ms_cnt != 16'd0) begin
         if (pre == pre_max) begin
            pre    <= '0;
            ms_cnt <= ms_cnt - 16'd1;
         end else begin
            pre <= pre + 17'd1;
         end
      end
   end

endmodule

// File: rtl/note_tone_player.sv
// Square-wave note player: tone for duration_ms, silence for gap_ms,
// then a one-cycle done pulse as it returns to idle.
module note_tone_player
   import note_pkg::*;
#(
   parameter int clk_mhz = 50
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [w_note-1:0] note,
   input  logic [1:0]        octave,
   input  logic [15:0]       duration_ms,
   input  logic [7:0]        gap_ms,
   output logic              ready,
   output logic              playing,
   output logic              tone,
   output logic              done
);

   tone_state_t state, state_nxt;

   logic [w_note-1:0]       note_lat;
   logic [1:0]              octave_lat;
   logic [7:0]              gap_lat;
   logic                    load, finish, expired, note_ok;
   logic [15:0]             load_ms;
   logic [19:0]             hcnt, half;
   logic [w_note-1:0][19:0] half_base;

   for (genvar i = 0; i < w_note; i++) begin : g_half
      assign half_base[i] = 20'(half_period(clk_mhz, freq_100_tab[i], 0));
   end

   always_comb begin
      half = '0;
      for (int i = 0; i < w_note; i++)
         if (note_lat[i]) half = half | half_base[i];
      half = half >> octave_lat;
   end

   // Zero or multi-hot codes play as a rest with unchanged timing.
   assign note_ok = (note_lat != '0) && ((note_lat & (note_lat - 12'd1)) == '0);

   assign ready   = (state == IDLE);
   assign playing = (state == PLAY);

   ms_timer #(.clk_mhz(clk_mhz)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .ms      (load_ms),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_ms   = '0;
      finish    = 1'b0;
      case (state)
         IDLE: if (start) begin
            if (duration_ms != 16'd0) begin
               state_nxt = PLAY;
               load      = 1'b1;
               load_ms   = duration_ms;
            end else if (gap_ms != 8'd0) begin
               state_nxt = GAP;
               load      = 1'b1;
               load_ms   = {8'd0, gap_ms};
            end else begin
               finish = 1'b1;
            end
         end
         PLAY: if (expired) begin
            if (gap_lat != 8'd0) begin
               state_nxt = GAP;
               load      = 1'b1;
               load_ms   = {8'd0, gap_lat};
            end else begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end
         end
         GAP: if (expired) begin
            state_nxt = IDLE;
            finish    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         note_lat   <= '0;
         octave_lat <= '0;
         gap_lat    <= '0;
         done       <= 1'b0;
         tone       <= 1'b0;
         hcnt       <= '0;
      end else begin
         done <= finish;
         if (state == IDLE && start) begin
            note_lat   <= note;
            octave_lat <= octave;
            gap_lat    <= gap_ms;
         end
         // Counting only while staying in PLAY restarts the phase on entry
         // and forces the output low the cycle after PLAY ends.
         if (state == PLAY && state_nxt == PLAY) begin
            if (hcnt == half - 20'd1) begin
               hcnt <= '0;
               tone <= tone ^ note_ok;
            end else begin
               hcnt <= hcnt + 20'd1;
            end
         end else begin
            hcnt <= '0;
            tone <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_note_tone_player.sv
// Bench for note_tone_player at 1 MHz: table of requests, hand sequences for
// start/reset corners, random traffic, all against a cycle-timeline model.
module tb_note_tone_player;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [11:0] note;
   logic [1:0]  octave;
   logic [15:0] duration_ms;
   logic [7:0]  gap_ms;
   logic        ready, playing, tone, done;

   always #5 clk = ~clk;

   note_tone_player #(.clk_mhz(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .note        (note),
      .octave      (octave),
      .duration_ms (duration_ms),
      .gap_ms      (gap_ms),
      .ready       (ready),
      .playing     (playing),
      .tone        (tone),
      .done        (done)
   );

   typedef struct {
      logic [11:0] note;
      logic [1:0]  oct;
      int          dur;
      int          gap;
      int          exp_play;
      int          exp_rise;
      int          exp_done;
   } vec_t;

   vec_t tbl [7];

   int vectors = 0, miscompares = 0, cyc = 0;

   // Model: one request described by its accept cycle and phase lengths.
   bit m_act = 0, m_valid = 0;
   int m_acc = 0, m_dcyc = 0, m_gcyc = 0, m_half = 1;

   int o_play, o_first_play, o_first_tone, o_done_cyc, o_done_cnt;

   // Note frequencies x100, C first.
   localparam int fr [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                              36999, 39200, 41530, 44000, 46616, 49388};

   function automatic int ref_half(logic [11:0] n, logic [1:0] o);
      for (int k = 0; k < 12; k++)
         if (n[11-k]) return (100000000 / (2 * fr[k])) >> o;
      return 1;
   endfunction

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic clear_obs();
      o_play = 0; o_first_play = -1; o_first_tone = -1; o_done_cyc = -1; o_done_cnt = 0;
   endtask

   // Called at a negedge: check this cycle, note any acceptance, advance.
   task automatic step();
      int rel, endc;
      logic er, ep, et, ed;
      er = 1'b1; ep = 1'b0; et = 1'b0; ed = 1'b0;
      if (m_act) begin
         rel  = cyc - m_acc;
         endc = m_acc + 1 + m_dcyc + m_gcyc;
         if (cyc >= endc) begin
            ed = (cyc == endc);
         end else begin
            er = 1'b0;
            ep = (rel >= 1) && (rel <= m_dcyc);
            et = ep && m_valid && ((((rel - 1) / m_half) % 2) == 1);
         end
      end
      chk("outputs{ready,playing,tone,done}", int'({ready, playing, tone, done}),
          int'({er, ep, et, ed}));
      if (playing) begin
         o_play++;
         if (o_first_play < 0) o_first_play = cyc;
      end
      if (tone && o_first_tone < 0) o_first_tone = cyc;
      if (done) begin
         o_done_cnt++;
         o_done_cyc = cyc;
      end
      if (er && start) begin
         m_act   = 1;
         m_acc   = cyc;
         m_dcyc  = int'(duration_ms) * 1000;
         m_gcyc  = int'(gap_ms) * 1000;
         m_valid = ($countones(note) == 1);
         m_half  = ref_half(note, octave);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to_done(int budget);
      int n = 0;
      while (o_done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acc, prev_done;

      tbl[0] = '{12'h004, 2'd0, 3, 0, 3000, 1136, 3001};
      tbl[1] = '{12'h004, 2'd1, 1, 2, 1000,  568, 3001};
      tbl[2] = '{12'h003, 2'd0, 2, 0, 2000,   -1, 2001};
      tbl[3] = '{12'h000, 2'd0, 2, 0, 2000,   -1, 2001};
      tbl[4] = '{12'h004, 2'd0, 0, 0,    0,   -1,    1};
      tbl[5] = '{12'h800, 2'd2, 1, 1, 1000,  477, 2001};
      tbl[6] = '{12'h001, 2'd3, 0, 1,    0,   -1, 1001};

      reset = 1'b1; start = 1'b0; note = '0; octave = '0; duration_ms = '0; gap_ms = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", int'({ready, playing, tone, done}), 4'b1000);
      reset = 1'b0;
      clear_obs();
      repeat (100) step();

      for (int i = 0; i < 7; i++) begin
         clear_obs();
         note = tbl[i].note; octave = tbl[i].oct;
         duration_ms = 16'(tbl[i].dur); gap_ms = 8'(tbl[i].gap);
         start = 1'b1;
         acc = cyc;
         step();
         start = 1'b0;
         note = 12'($urandom); octave = 2'($urandom);
         duration_ms = 16'($urandom_range(1, 3)); gap_ms = 8'($urandom_range(1, 3));
         run_to_done(tbl[i].exp_done + 100);
         chk("play_cycles", o_play, tbl[i].exp_play);
         chk("first_rise", (o_first_tone < 0) ? -1 : o_first_tone - o_first_play, tbl[i].exp_rise);
         chk("done_offset", (o_done_cyc < 0) ? -1 : o_done_cyc - acc, tbl[i].exp_done);
         repeat (3) step();
      end

      // start during PLAY is ignored; the latched note keeps sounding
      clear_obs();
      note = 12'h004; octave = 2'd0; duration_ms = 16'd2; gap_ms = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (500) step();
      note = 12'h800; duration_ms = 16'd1; start = 1'b1;
      repeat (3) step();
      start = 1'b0;
      run_to_done(3000);
      chk("ignored_start_play", o_play, 2000);
      chk("ignored_start_rise", (o_first_tone < 0) ? -1 : o_first_tone - o_first_play, 1136);
      repeat (3) step();

      // start held across completion: re-accepted in the done cycle
      clear_obs();
      note = 12'h004; octave = 2'd1; duration_ms = 16'd1; gap_ms = 8'd0; start = 1'b1;
      acc = cyc;
      step();
      run_to_done(1100);
      start = 1'b0;
      chk("held_first_done", (o_done_cyc < 0) ? -1 : o_done_cyc - acc, 1001);
      prev_done = o_done_cyc;
      clear_obs();
      run_to_done(1100);
      chk("held_reaccept_done", (o_done_cyc < 0) ? -1 : o_done_cyc - prev_done, 1001);
      repeat (3) step();

      // asynchronous reset in the middle of PLAY
      clear_obs();
      note = 12'h800; octave = 2'd0; duration_ms = 16'd5; gap_ms = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (1499) step();
      reset = 1'b1;
      #1;
      chk("async_reset_ready_playing_tone", int'({ready, playing, tone}), 3'b100);
      m_act = 0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      chk("reset_no_done", int'(done), 0);
      reset = 1'b0;
      clear_obs();
      repeat (20) step();
      chk("reset_done_count", o_done_cnt, 0);
      note = 12'h004; octave = 2'd0; duration_ms = 16'd1; gap_ms = 8'd0; start = 1'b1;
      acc = cyc;
      step();
      start = 1'b0;
      run_to_done(1100);
      chk("after_reset_done", (o_done_cyc < 0) ? -1 : o_done_cyc - acc, 1001);

      // random traffic against the model
      repeat (12000) begin
         start = ($urandom_range(0, 9) == 0);
         note = ($urandom_range(0, 1) == 1) ? (12'd1 << $urandom_range(0, 11)) : 12'($urandom);
         octave = 2'($urandom);
         duration_ms = 16'($urandom_range(0, 2));
         gap_ms = 8'($urandom_range(0, 2));
         step();
      end
      start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
